// File: rtl/eth_tx_framer.sv
`timescale 1ns/1ps
// Ethernet transmit framer: wraps a payload byte stream with preamble, SFD,
// zero padding and CRC-32 FCS, then enforces an inter-frame gap.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       err_underrun,
  output logic       err_oversize
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [11:0] MIN_C    = 12'(MIN_FRAME);
  localparam logic [10:0] MAX_C    = 11'(MAX_FRAME);

  state_t      state;
  logic [15:0] idx;
  logic [10:0] count;
  logic [31:0] crc;
  logic [11:0] count_nx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign count_nx = {1'b0, count} + 12'd1;
  assign s_ready  = (state == DATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      count        <= '0;
      crc          <= 32'hFFFF_FFFF;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          if (s_valid) begin
            state <= PRE;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        PRE: begin
          tx_data  <= 8'h55;
          tx_valid <= 1'b1;
          if (idx == PRE_LAST) state <= SFD;
          else idx <= idx + 16'd1;
        end
        SFD: begin
          tx_data <= 8'hD5;
          crc     <= 32'hFFFF_FFFF;
          count   <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (!s_valid) begin
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            err_underrun <= 1'b1;
            state        <= IFG;
            idx          <= 16'd1;
          end else if (count == MAX_C && !s_last) begin
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            err_oversize <= 1'b1;
            state        <= IFG;
            idx          <= 16'd1;
          end else begin
            tx_data <= s_data;
            crc     <= crc_byte(crc, s_data);
            if (count != MAX_C) count <= count + 11'd1;
            if (s_last) begin
              idx <= '0;
              if (count_nx < MIN_C) state <= PAD;
              else state <= FCS;
            end
          end
        end
        PAD: begin
          tx_data <= 8'h00;
          crc     <= crc_byte(crc, 8'h00);
          count   <= count + 11'd1;
          if (count_nx >= MIN_C) state <= FCS;
        end
        FCS: begin
          tx_data <= ~crc[{idx[1:0], 3'b000} +: 8];
          if (idx[1:0] == 2'd3) begin
            state <= IFG;
            idx   <= 16'd1;
          end else idx <= idx + 16'd1;
        end
        IFG: begin
          // The IDLE cycle that follows is the final gap cycle, so IFG starts counting at 1.
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          if (idx >= IFG_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else idx <= idx + 16'd1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
`timescale 1ns/1ps
// Directed bench for eth_tx_framer: table of packet vectors plus hand-written
// sequences for back-to-back, underrun, oversize and mid-frame reset.
module tb_eth_tx_framer;
  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_last = 1'b0;
  logic       s_ready, tx_valid, busy, err_underrun, err_oversize;
  logic [7:0] tx_data;
  logic       s_ready0, tx_valid0, busy0, err_underrun0, err_oversize0;
  logic [7:0] tx_data0;

  always #4 clk = ~clk;

  eth_tx_framer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .err_underrun(err_underrun), .err_oversize(err_oversize));

  eth_tx_framer #(.MIN_FRAME(0)) dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0), .busy(busy0),
    .err_underrun(err_underrun0), .err_oversize(err_oversize0));

  typedef struct {
    int len;
    int base;
    int exp_len;
  } vec_t;

  int         passed = 0, total = 0, cyc = 0, t_start = 0;
  logic [7:0] cap_q[$], cap0_q[$], exp_q[$], pay_q[$];
  int         rise_q[$], fall_q[$];
  int         n_und = 0, n_ovr = 0, pos = 0;
  logic       prev_v = 1'b0, sfd_rdy = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_valid) begin
      cap_q.push_back(tx_data);
      pos++;
      if (pos == 8) sfd_rdy = s_ready;
    end else pos = 0;
    if (tx_valid && !prev_v) rise_q.push_back(cyc);
    if (!tx_valid && prev_v) fall_q.push_back(cyc);
    prev_v = tx_valid;
    if (tx_valid0) cap0_q.push_back(tx_data0);
    if (err_underrun) n_und++;
    if (err_oversize) n_ovr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_m(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      logic fb;
      fb = r[0] ^ b[k];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] last4(input logic [7:0] q[$]);
    int n;
    n = q.size();
    if (n < 4) return 32'h0;
    return {q[n-1], q[n-2], q[n-3], q[n-4]};
  endfunction

  function automatic int qi(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -9999;
  endfunction

  task automatic clear_mon();
    cap_q.delete(); cap0_q.delete(); rise_q.delete(); fall_q.delete();
    n_und = 0; n_ovr = 0; pos = 0; sfd_rdy = 1'b0;
  endtask

  task automatic fill_pay(input int len, input int base);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'(base + i));
  endtask

  task automatic build_exp(input int minf);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c   = 32'hFFFF_FFFF;
    tot = (pay_q.size() < minf) ? minf : pay_q.size();
    for (int i = 0; i < tot; i++) begin
      b = (i < pay_q.size()) ? pay_q[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_m(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic send_pkt(input bit last_en, input bit hold);
    int   i = 0, guard = 0;
    logic rdy;
    t_start = cyc;
    s_valid = 1'b1;
    while (i < pay_q.size() && guard < 5000) begin
      s_data = pay_q[i];
      s_last = last_en && (i == pay_q.size() - 1);
      rdy    = s_ready;
      @(posedge clk); #1;
      if (rdy) i++;
      guard++;
    end
    chk("send_accepted", i, pay_q.size());
    s_last = 1'b0;
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    repeat (16) @(negedge clk);
  endtask

  task automatic chk_frame(input string name, input int exp_len);
    int bad = -1;
    chk({name, "_len"}, cap_q.size(), exp_len);
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++)
      if (bad < 0 && cap_q[k] !== exp_q[k]) bad = k;
    if (bad < 0 && cap_q.size() != exp_q.size())
      bad = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    chk({name, "_first_bad_byte"}, bad, -1);
    chk({name, "_fcs"}, last4(cap_q), last4(exp_q));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    vt[0] = '{60, 8'h00, 72};
    vt[1] = '{1,  8'hAB, 72};
    vt[2] = '{64, 8'h10, 76};
    vt[3] = '{59, 8'hC0, 72};

    #13;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_underrun, err_oversize}, 0);
    #9 rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      fill_pay(vt[v].len, vt[v].base);
      clear_mon();
      send_pkt(1'b1, 1'b0);
      wait_idle();
      build_exp(60);
      chk_frame($sformatf("vec%0d", v), vt[v].exp_len);
      chk($sformatf("vec%0d_no_err", v), n_und + n_ovr, 0);
      chk($sformatf("vec%0d_one_frame", v), rise_q.size(), 1);
      if (v == 0) begin
        chk("first_pre_latency", qi(rise_q, 0) - t_start, 2);
        chk("valid_run", qi(fall_q, 0) - qi(rise_q, 0), 72);
        chk("sfd_s_ready", sfd_rdy, 1);
      end
    end

    // "123456789" on the unpadded instance gives the standard check value.
    fill_pay(9, 8'h31);
    clear_mon();
    send_pkt(1'b1, 1'b0);
    wait_idle();
    chk("crc9_len", cap0_q.size(), 21);
    chk("crc9_fcs", last4(cap0_q), 32'hCBF43926);
    build_exp(60);
    chk_frame("pad9", 72);

    // Back-to-back with s_valid never dropping.
    clear_mon();
    fill_pay(60, 8'h00);
    send_pkt(1'b1, 1'b1);
    fill_pay(60, 8'h40);
    send_pkt(1'b1, 1'b0);
    wait_idle();
    chk("b2b_frames", rise_q.size(), 2);
    chk("b2b_len", cap_q.size(), 144);
    chk("b2b_gap", qi(rise_q, 1) - qi(fall_q, 0), 12);

    // Underrun after 20 payload bytes.
    clear_mon();
    fill_pay(20, 8'h90);
    send_pkt(1'b0, 1'b0);
    wait_idle();
    chk("und_len", cap_q.size(), 28);
    chk("und_pulse", n_und, 1);
    chk("und_last_byte", (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 8'h00, 8'hA3);
    chk("und_run", qi(fall_q, 0) - qi(rise_q, 0), 28);
    chk("und_frames", rise_q.size(), 1);

    // Oversize: 1515 bytes, no s_last.
    clear_mon();
    fill_pay(1515, 8'h00);
    send_pkt(1'b0, 1'b0);
    wait_idle();
    chk("ovr_len", cap_q.size(), 1522);
    chk("ovr_pulse", n_ovr, 1);
    chk("ovr_no_und", n_und, 0);
    chk("ovr_last_byte", (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 8'h00, 8'hE9);
    chk("ovr_fall", fall_q.size(), 1);

    // Asynchronous reset mid-payload, then a clean frame.
    clear_mon();
    s_valid = 1'b1;
    s_data  = 8'h5A;
    s_last  = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    chk("pre_rst_active", {busy, tx_valid, s_ready}, 3'b111);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ctl", {tx_valid, s_ready, busy}, 0);
    chk("midrst_data", tx_data, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    clear_mon();
    fill_pay(10, 8'h20);
    send_pkt(1'b1, 1'b0);
    wait_idle();
    build_exp(60);
    chk_frame("post_rst", 72);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-stream Ethernet transmit framer. It sits directly upstream of the RGMII transmit stage and replaces the ad-hoc byte multiplexer in the top level. It accepts a payload byte stream (destination MAC through end of UDP payload) over a valid/ready/last handshake. It emits one complete wire frame per packet: preamble, SFD, payload, zero padding to minimum size, CRC-32 FCS, then a mandatory inter-frame gap.

## Interface
Parameters:
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD.
- `MIN_FRAME`, 60: minimum payload+pad bytes before the FCS; 0 disables padding.
- `MAX_FRAME`, 1514: maximum payload bytes; exceeding it is an error.
- `IFG_CYCLES`, 12: idle cycles after the last FCS byte.

Ports:
- `clk`  in  1: transmit clock (125 MHz, the RGMII tx clock domain).
- `rst`  in  1: reset, asynchronous, active-low.
- `s_data`  in  8: payload byte.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: `s_data` is the final payload byte.
- `s_ready`  out  1: framer accepts `s_data` this cycle.
- `tx_data`  out  8: byte to the RGMII transmitter.
- `tx_valid`  out  1: `tx_data` is part of a frame (becomes RGMII TX_CTL).
- `busy`  out  1: high whenever the state is not IDLE.
- `err_underrun`  out  1: one-cycle pulse when the frame is aborted because `s_valid` was low mid-payload.
- `err_oversize`  out  1: one-cycle pulse when the frame is aborted because the payload exceeded `MAX_FRAME`.

## Operation
- Reset (asserted): state IDLE; `tx_data`=0x00; `tx_valid`, `s_ready`, `busy`, `err_*` all 0; CRC=0xFFFFFFFF; counters 0.
- All outputs are registered except `s_ready`, which is decoded from the state (`s_ready` = state==DATA).
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: when `s_valid`=1, go to PRE. No byte is consumed in IDLE.
- PRE: output 0x55 for `PREAMBLE_LEN` cycles, then go to SFD.
- SFD: output 0xD5, then go to DATA. CRC and byte count are cleared to 0xFFFFFFFF and 0.
- DATA: on `s_valid`&`s_ready`, the byte is registered to `tx_data`, CRC is updated and the count is incremented.
  - On `s_last`: if count+1 < `MIN_FRAME`, go to PAD; else go to FCS.
- PAD: output 0x00 and update CRC with each pad byte until count == `MIN_FRAME`, then go to FCS.
- FCS: output the 4 bytes of ~CRC, least significant byte first, then go to IFG.
- IFG: `tx_valid`=0 for `IFG_CYCLES` cycles, then go to IDLE. `busy` stays high throughout.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, processed one byte per cycle, LSB first. Covers payload and pad only; preamble and SFD are excluded.
- Underrun: `s_valid`=0 in DATA.
  - Next edge: `tx_valid`=0, `err_underrun` pulses, state goes to IFG.
  - No FCS is sent; the frame is truncated on the wire.
- Oversize: a byte accepted at count == `MAX_FRAME` without `s_last`.
  - That byte is not forwarded; `err_oversize` pulses; `tx_valid`=0; state goes to IFG.
  - Upstream must flush the rest of the packet.
- Count is 11 bits and saturates at `MAX_FRAME`; it never wraps.
- Reset mid-frame: all outputs return to their reset values immediately; the partial frame is abandoned.

## Timing
- Edge 0 samples `s_valid`=1 in IDLE.
- `tx_valid` rises after edge 1 with `tx_data`=0x55. The first preamble byte appears 1 cycle after `s_valid` in IDLE.
- The SFD is on `tx_data` in cycle `PREAMBLE_LEN`+1. `s_ready` is high in that same cycle.
- A payload byte accepted on edge n is on `tx_data` after edge n+1. Latency is 1 cycle and throughput is 1 byte/cycle.
- `tx_valid` is high continuously from the first preamble byte through the last FCS byte. There are no bubbles.
- Frame length on the wire, in `tx_valid` cycles: `PREAMBLE_LEN`+1 + max(payload,`MIN_FRAME`) + 4.
- Minimum spacing from the last FCS byte to the next preamble byte is `IFG_CYCLES`+1 cycles.
- `s_ready` is 0 in the cycle after `s_last` is accepted. It stays 0 until the next frame's SFD cycle.

## Test plan
- 60-byte payload 0x00..0x3B, `s_valid` held high -> exactly 72 `tx_valid` cycles: 7×0x55, 0xD5, 0x00..0x3B, 4 FCS bytes that match the software CRC model; then 12 idle cycles.
- `MIN_FRAME`=0, payload ASCII "123456789" -> FCS bytes 0x26, 0x39, 0xF4, 0xCB.
- 1-byte payload 0xAB -> 0xAB, then 59×0x00, then FCS over all 60 bytes; 72 `tx_valid` cycles in total.
- Two back-to-back packets with `s_valid` never dropping -> the second preamble starts exactly 13 cycles after the first packet's last FCS byte.
- `s_valid` dropped at payload byte 20 -> `tx_valid` falls on the next edge, `err_underrun`=1 for 1 cycle, no FCS, then 12-cycle gap and back to IDLE.
- 1515-byte packet with no `s_last` -> 1514 bytes forwarded, `err_oversize` pulses, `tx_valid` falls.
- `rst` low mid-payload -> `tx_valid`/`s_ready`/`busy`=0 asynchronously; after release, a new frame starts with a full preamble.
